ctrl_sequencer: RTL
===================

Name: ctrl_sequencer

Overview:
- Hardwired control unit that drives the existing datapath's control strobes.
- Replaces the hand-scripted state sequences currently used in datapath benches.
- Runs instruction fetch, then decodes IR[31:27] and steps the per-opcode T-state sequence for ld, ldi, st, add, sub, and, or and halt.
- Sits directly upstream of the datapath: consumes IR and emits every bus, register and memory strobe.

Parameters:
- MEM_WAIT, 0: extra wait cycles added to every memory read state (fetch T1, ld T6) and to the st write state; range 0..7.
- OPW, 5: opcode width, taken from IR[31:27].

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- IR  in  32  instruction register contents from the datapath.
- stop  in  1  halt request, sampled only at instruction boundaries.
- PCout, Zlowout, MDRout, Cout, BAout, Rout  out  1 each  bus drive enables.
- PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin  out  1 each  register load enables.
- IncPc  out  1  ALU PC+1 select.
- read, write  out  1 each  memory strobes.
- mdr_read  out  2  MDR source select: 00 = bus, 01 = memory.
- control  out  4  ALU operation code.
- GRA, GRB, GRC  out  1 each  register-field selects for the Ra, Rb and Rc fields.
- run  out  1  1 = executing, 0 = halted or in reset.

Behaviour:
- Reset:
  - All outputs are 0; mdr_read = 00, control = 0, run = 0.
  - The state machine is in RST.
  - On the first posedge with reset = 1: RST -> T0, run = 1.
  - Reset asserted mid-instruction aborts immediately; no partial strobes persist.
- Output style: Moore, decoded from the state register. Any strobe not listed for a state is 0 in that state; each listed strobe is high for exactly that state.
- Fetch:
  - T0: PCout, MARin, IncPc, Zlowin.
  - T1: Zlowout, PCin, read, mdr_read = 01, MDRin.
  - T2: MDRout, IRin.
  - T3 decodes IR[31:27], which is stable from the T2 load.
- T1 with MEM_WAIT = N:
  - T1 lasts 1+N cycles. read and mdr_read = 01 are held for all of them.
  - Zlowout, PCin and MDRin are asserted only in the final cycle.
  - A 3-bit wait counter loads N on entry and decrements to 0.
- ld (00000):
  - T3: GRB, BAout, Yin.
  - T4: Cout, control = ADD, Zlowin.
  - T5: Zlowout, MARin.
  - T6: read, mdr_read = 01, MDRin, stretched by MEM_WAIT exactly as T1.
  - T7: MDRout, GRA, Rin.
  - Total 8 + 2*MEM_WAIT cycles.
- ldi (00001): T3 and T4 as ld; T5: Zlowout, GRA, Rin. Total 6 + MEM_WAIT cycles.
- st (00010):
  - T3–T5 as ld.
  - T6: GRA, Rout, MDRin, mdr_read = 00.
  - T7: write, held for 1+MEM_WAIT cycles.
  - Total 8 + 2*MEM_WAIT cycles.
- add/sub/and/or (00011/00100/00101/00110):
  - T3: GRB, Rout, Yin.
  - T4: GRC, Rout, control = ALU code, Zlowin.
  - T5: Zlowout, GRA, Rin.
  - Total 6 + MEM_WAIT cycles.
- ALU codes: ADD = 2, SUB = 3, AND = 4, OR = 5.
- halt (11011): T3 -> HALT. In HALT, run = 0 and all strobes are 0; only reset leaves it.
- Any other opcode is a NOP: T3 -> T0.
- Instruction boundary (last state of every sequence):
  - Next state is T0 if stop = 0, else HALT.
  - stop asserted at any other time has no effect until the next boundary.
- Simultaneous stop and halt opcode: HALT (same result).
- read and write are never both 1 in any state.
- The state encoding is 5-bit; unreachable encodings go to RST on the next clock.

Decomposition:
- ctrl_pkg:
  - Opcode constants OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_HALT.
  - ALU codes ALU_ADD..ALU_OR.
  - State enum RST, T0–T7, HALT, with per-opcode execute states.
  - mdr_read codes MDR_BUS, MDR_MEM.
- One sub-module, ctrl_wait_counter: load, decrement, done flag; instantiated once and shared by T1, T6 and T7.

Test Plan:
1. Reset low for 3 cycles, then high; IR = 0x08000015 (ldi R0, 0x15), MEM_WAIT = 0 -> the first cycle after release is T0 with PCout, MARin, IncPc, Zlowin all 1. Exactly 6 cycles later the bench is back in T0, and GRA & Rin are seen for 1 cycle.
2. IR = 0x00800055 (ld R1, 0x55) -> exact strobe sequence T0..T7 as specified. mdr_read = 01 in T6, control = 2 in T4; 8 cycles per instruction.
3. IR = 0x1080005A (st R1, 0x5A) -> write = 1 only in T7, MDRin with mdr_read = 00 in T6, read = 0 throughout T3–T7.
4. IR = 0x19890000 (add R3, R1, R2) then sub/and/or variants -> control = 2/3/4/5 in T4, GRC & Rout in T4, GRA & Rin in T5.
5. IR = 0xD8000000 (halt) -> run falls to 0 after T3 and all outputs stay 0 for 20 cycles. With stop = 1 raised during ld T4 instead, run falls only after ld T7 completes.
6. MEM_WAIT = 3, ld -> read held 4 cycles in T1 and in T6, MDRin only in the last of each; 14 cycles total. Reset pulsed low during T6 -> all outputs 0 asynchronously, and restart from T0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU codes, sequencer states and the control-strobe bundle
// for the hardwired control unit.
package ctrl_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned WAIT_W = 3;

  localparam logic [OP_W-1:0] OP_LD   = 5'd0;
  localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OP_W-1:0] OP_ST   = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OP_AND  = 5'd5;
  localparam logic [OP_W-1:0] OP_OR   = 5'd6;
  localparam logic [OP_W-1:0] OP_HALT = 5'd27;

  localparam logic [CTRL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'd3;
  localparam logic [CTRL_W-1:0] ALU_AND = 4'd4;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'd5;

  localparam logic [1:0] MDR_BUS = 2'b00;
  localparam logic [1:0] MDR_MEM = 2'b01;

  // Fetch/decode states, then per-opcode execute states.
  typedef enum logic [4:0] {
    RST    = 5'd0,
    T0     = 5'd1,
    T1     = 5'd2,
    T2     = 5'd3,
    T3     = 5'd4,
    LD_T4  = 5'd5,
    LD_T5  = 5'd6,
    LD_T6  = 5'd7,
    LD_T7  = 5'd8,
    LDI_T5 = 5'd9,
    ST_T6  = 5'd10,
    ST_T7  = 5'd11,
    ALU_T4 = 5'd12,
    ALU_T5 = 5'd13,
    HALT   = 5'd14
  } state_t;

  typedef struct packed {
    logic              pc_out;
    logic              zlow_out;
    logic              mdr_out;
    logic              c_out;
    logic              ba_out;
    logic              r_out;
    logic              pc_in;
    logic              mar_in;
    logic              mdr_in;
    logic              ir_in;
    logic              y_in;
    logic              zlow_in;
    logic              r_in;
    logic              inc_pc;
    logic              read;
    logic              write;
    logic [1:0]        mdr_read;
    logic [CTRL_W-1:0] control;
    logic              gra;
    logic              grb;
    logic              grc;
    logic              run;
  } strobes_t;

  function automatic logic [CTRL_W-1:0] alu_code(input logic [OP_W-1:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Memory wait-state counter: preloads the wait count, counts down while a
// memory state is stretched, and flags the final cycle.
module ctrl_wait_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired control unit: instruction fetch, IR opcode decode and per-opcode
// T-state sequencing of every datapath bus, register and memory strobe.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned OPW      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Rin,
  output logic        IncPc,
  output logic        read,
  output logic        write,
  output logic [1:0]  mdr_read,
  output logic [3:0]  control,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        run
);

  state_t           state_q;
  state_t           state_d;
  state_t           boundary_c;
  strobes_t         s;
  logic [OP_W-1:0]  op;
  logic             in_wait_c;
  logic             wait_done_c;
  logic             unused_ir;

  assign op        = OP_W'(IR[31 -: OPW]);
  assign unused_ir = ^IR[31-OPW:0];

  // One counter serves all three stretchable memory states (never adjacent).
  assign in_wait_c = (state_q == T1) || (state_q == LD_T6) || (state_q == ST_T7);

  ctrl_wait_counter #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (!in_wait_c),
    .dec      (in_wait_c && !wait_done_c),
    .load_val (WAIT_W'(MEM_WAIT)),
    .done_c   (wait_done_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RST;
    end else begin
      state_q <= state_d;
    end
  end

  assign boundary_c = stop ? HALT : T0;

  // Next-state: stop is honoured only in the last state of each sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:    state_d = T0;
      T0:     state_d = T1;
      T1:     if (wait_done_c) state_d = T2;
      T2:     state_d = T3;
      T3: begin
        case (op)
          OP_LD, OP_LDI, OP_ST:           state_d = LD_T4;
          OP_ADD, OP_SUB, OP_AND, OP_OR:  state_d = ALU_T4;
          OP_HALT:                        state_d = HALT;
          default:                        state_d = boundary_c;
        endcase
      end
      LD_T4:  state_d = (op == OP_LDI) ? LDI_T5 : LD_T5;
      LD_T5:  state_d = (op == OP_ST) ? ST_T6 : LD_T6;
      LD_T6:  if (wait_done_c) state_d = LD_T7;
      LD_T7:  state_d = boundary_c;
      LDI_T5: state_d = boundary_c;
      ST_T6:  state_d = ST_T7;
      ST_T7:  if (wait_done_c) state_d = boundary_c;
      ALU_T4: state_d = ALU_T5;
      ALU_T5: state_d = boundary_c;
      HALT:   state_d = HALT;
      default: state_d = RST;
    endcase
  end

  // Moore strobe decode; T3 also looks at the freshly loaded IR opcode.
  always_comb begin
    s     = '0;
    s.run = 1'b1;
    case (state_q)
      T0: begin
        s.pc_out  = 1'b1;
        s.mar_in  = 1'b1;
        s.inc_pc  = 1'b1;
        s.zlow_in = 1'b1;
      end
      T1: begin
        s.read     = 1'b1;
        s.mdr_read = MDR_MEM;
        s.zlow_out = wait_done_c;
        s.pc_in    = wait_done_c;
        s.mdr_in   = wait_done_c;
      end
      T2: begin
        s.mdr_out = 1'b1;
        s.ir_in   = 1'b1;
      end
      T3: begin
        case (op)
          OP_LD, OP_LDI, OP_ST: begin
            s.grb    = 1'b1;
            s.ba_out = 1'b1;
            s.y_in   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            s.grb   = 1'b1;
            s.r_out = 1'b1;
            s.y_in  = 1'b1;
          end
          default: ;
        endcase
      end
      LD_T4: begin
        s.c_out   = 1'b1;
        s.control = ALU_ADD;
        s.zlow_in = 1'b1;
      end
      LD_T5: begin
        s.zlow_out = 1'b1;
        s.mar_in   = 1'b1;
      end
      LD_T6: begin
        s.read     = 1'b1;
        s.mdr_read = MDR_MEM;
        s.mdr_in   = wait_done_c;
      end
      LD_T7: begin
        s.mdr_out = 1'b1;
        s.gra     = 1'b1;
        s.r_in    = 1'b1;
      end
      LDI_T5, ALU_T5: begin
        s.zlow_out = 1'b1;
        s.gra      = 1'b1;
        s.r_in     = 1'b1;
      end
      ST_T6: begin
        s.gra      = 1'b1;
        s.r_out    = 1'b1;
        s.mdr_in   = 1'b1;
        s.mdr_read = MDR_BUS;
      end
      ST_T7: s.write = 1'b1;
      ALU_T4: begin
        s.grc     = 1'b1;
        s.r_out   = 1'b1;
        s.control = alu_code(op);
        s.zlow_in = 1'b1;
      end
      default: s.run = 1'b0;
    endcase
  end

  assign PCout    = s.pc_out;
  assign Zlowout  = s.zlow_out;
  assign MDRout   = s.mdr_out;
  assign Cout     = s.c_out;
  assign BAout    = s.ba_out;
  assign Rout     = s.r_out;
  assign PCin     = s.pc_in;
  assign MARin    = s.mar_in;
  assign MDRin    = s.mdr_in;
  assign IRin     = s.ir_in;
  assign Yin      = s.y_in;
  assign Zlowin   = s.zlow_in;
  assign Rin      = s.r_in;
  assign IncPc    = s.inc_pc;
  assign read     = s.read;
  assign write    = s.write;
  assign mdr_read = s.mdr_read;
  assign control  = s.control;
  assign GRA      = s.gra;
  assign GRB      = s.grb;
  assign GRC      = s.grc;
  assign run      = s.run;

endmodule
